serial_adder_seq: RTL and testbench
===================================

Name: serial_adder_seq

Overview:
- Parametrised multi-cycle adder and successor to the gate-level half/full adder pair.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first, through a registered carry chain.
- Start/done handshake lets a small controller issue wide additions with a single narrow adder slice.
- Sits beside the combinational adders as the area-optimised variant.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 1, bits added per cycle; must divide WIDTH exactly. Elaboration-time error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- A  input  WIDTH  operand A; captured on the accepting edge
- B  input  WIDTH  operand B; captured on the accepting edge
- Cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while a digit is being processed
- done  output  1  one-cycle pulse; Sum and Carry are valid
- Sum  output  WIDTH  result; holds until the next completion
- Carry  output  1  carry-out of the MSB; holds with Sum

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, state=IDLE, busy=0, done=0, Sum=0, Carry=0, and the internal digit counter, carry register and operand shadows are cleared.
- N = WIDTH/DIGIT.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, counter k counts 0..N-1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE with start=1: capture A, B and Cin into shadows; carry register = Cin; k=0; go to RUN.
  - IDLE with start=0: stay in IDLE.
  - RUN, each edge: add digit k of A, digit k of B and the carry register. Write the DIGIT-bit result into digit k of the result shadow, write the digit carry-out into the carry register, then k=k+1.
  - RUN at the edge processing k=N-1: copy the result shadow to Sum and the final carry to Carry; go to DONE.
  - DONE with start=1: accept a new request exactly as IDLE does and go to RUN (back-to-back operation).
  - DONE with start=0: go to IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge N. Back-to-back throughput is one result per N+1 cycles.
- Sum and Carry change only on the completion edge or on reset. During RUN they keep the previous result.
- start while busy=1 is ignored; no queueing. Changes on A, B or Cin while busy have no effect.
- Reset mid-RUN aborts the operation with no done pulse; all outputs return to their reset values on that edge.
- Arithmetic is unsigned modulo 2^WIDTH, and Carry is bit WIDTH of A+B+Cin. For WIDTH=1, DIGIT=1 the result must match the full adder truth table after a 1-cycle latency.
- rst has priority over start on the same edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port Sub (1 bit), captured with the operands.
  - Effective operand B' = B XOR {WIDTH{Sub}}; effective carry-in = Cin XOR Sub.
  - Sub=1 with Cin=0 gives A-B, and Carry=1 means no borrow.
- Undefined: no Sub port; behaviour is pure addition as above.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Helper function for counter width: clog2 of N, minimum 1.
- One sub-module, serial_digit_add: combinational DIGIT-bit ripple adder built from full-adder cells.
  - Inputs: a[DIGIT], b[DIGIT], ci.
  - Outputs: s[DIGIT], co.
- The top level holds the FSM, counter, shadows and result registers.

Test Plan:
- WIDTH=8, DIGIT=1; A=8'hFF, B=8'h01, Cin=0, start pulsed -> busy high for 8 cycles, done in cycle 9, Sum=8'h00, Carry=1.
- WIDTH=1, DIGIT=1; sweep all 8 combinations of A, B, Cin -> each Sum/Carry matches the full adder truth table; done 1 cycle after each start.
- WIDTH=8, DIGIT=4; A=8'h3C, B=8'hA5, Cin=1 -> done after 2 cycles, Sum=8'hE2, Carry=0. A second start in the done cycle is accepted and completes 2 cycles later.
- Start at 8'h10+8'h20; re-pulse start with 8'hFF+8'hFF at cycle 3 -> second request ignored; Sum=8'h30, Carry=0, exactly one done pulse.
- Assert rst at cycle 4 of an 8-cycle run -> next cycle busy=0, done=0, Sum=0, Carry=0; no done pulse; a fresh start afterwards completes normally.
- SERIAL_ADDER_SUB_EN defined; A=8'h05, B=8'h07, Sub=1, Cin=0 -> Sum=8'hFE, Carry=0. With A=8'h07, B=8'h05 -> Sum=8'h02, Carry=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for the serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_digit_add.sv
// serial_digit_add: combinational DIGIT-bit ripple adder built from full-adder cells.
module serial_digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[DIGIT];
endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle adder, DIGIT bits per clock LSB first with start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the Sub port (A-B via inverted B and carry-in).
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] KMAX = CW'(N - 1);
  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder_seq: DIGIT must divide WIDTH and WIDTH must be >= 1");
  end
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic [DIGIT-1:0] s;
  logic [CW-1:0] k;
  logic cy, co, sub, acc, last;
  int idx;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = Sub;
`else
  assign sub = 1'b0;
`endif
  assign idx  = int'(k) * DIGIT;
  assign acc  = start && state != RUN;
  assign last = k == KMAX;
  assign busy = state == RUN;
  assign done = state == DONE;
  serial_digit_add #(.DIGIT(DIGIT)) u_dig (
    .a (a_sh[idx +: DIGIT]),
    .b (b_sh[idx +: DIGIT]),
    .ci(cy),
    .s (s),
    .co(co)
  );
  always_comb begin
    r_nx = r_sh;
    r_nx[idx +: DIGIT] = s;
  end
  always_comb nxt = busy ? (last ? DONE : RUN) : (acc ? RUN : IDLE);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // DONE accepts a new request just like IDLE, giving one result per N+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cy    <= 1'b0;
      k     <= '0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else if (acc) begin
      a_sh <= A;
      b_sh <= B ^ {WIDTH{sub}};
      r_sh <= '0;
      cy   <= Cin ^ sub;
      k    <= '0;
    end else if (busy) begin
      r_sh <= r_nx;
      cy   <= co;
      k    <= last ? '0 : k + 1'b1;
      if (last) begin
        Sum   <= r_nx;
        Carry <= co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: randomized self-checking bench for three serial_adder_seq configurations.
module tb_serial_adder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [7:0] a = '0, b = '0;
  logic cin = 1'b0, sub = 1'b0;
  logic [2:0] busy, done, carry;
  logic [7:0] sum8a, sum8c;
  logic sum1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .busy(busy[0]), .done(done[0]), .Sum(sum8a), .Carry(carry[0]));
  serial_adder_seq #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .A(a[0]), .B(b[0]), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .busy(busy[1]), .done(done[1]), .Sum(sum1), .Carry(carry[1]));
  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub),
`endif
    .busy(busy[2]), .done(done[2]), .Sum(sum8c), .Carry(carry[2]));

  function automatic logic [7:0] sum_of(input int sel);
    return (sel == 0) ? sum8a : (sel == 1) ? {7'd0, sum1} : sum8c;
  endfunction

  // Reference: plain integer arithmetic on the (optionally inverted) operands.
  function automatic int model(input int w, input logic [7:0] x, input logic [7:0] y,
                               input logic ci, input logic sb);
    int m = (1 << w) - 1;
    logic [7:0] yy = sb ? ~y : y;
    return (int'(x) & m) + (int'(yy) & m) + int'(ci ^ sb);
  endfunction

  task automatic go(input int sel, input logic [7:0] x, input logic [7:0] y, input logic ci,
                    output int lat, output int bc);
    @(negedge clk);
    a = x; b = y; cin = ci; start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 0; bc = 0;
    while (!done[sel] && lat < 40) begin
      if (busy[sel]) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b want 000", busy); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done got %b want 000", done); end
    checks++; if (carry !== 3'b000) begin errors++; $display("FAIL reset_carry got %b want 000", carry); end
    checks++; if ({sum8a, sum8c, sum1} !== 17'd0) begin errors++; $display("FAIL reset_sum got %h %h %b want 0", sum8a, sum8c, sum1); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    go(0, 8'hFF, 8'h01, 1'b0, lat, bc);
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    checks++; if (sum8a !== 8'h00) begin errors++; $display("FAIL basic_sum got %h want 00", sum8a); end
    checks++; if (carry[0] !== 1'b1) begin errors++; $display("FAIL basic_carry got %b want 1", carry[0]); end
    @(negedge clk);
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done[0]); end
    checks++; if (sum8a !== 8'h00 || carry[0] !== 1'b1) begin errors++; $display("FAIL basic_hold got %h/%b want 00/1", sum8a, carry[0]); end
  endtask

  task automatic test_full_adder;
    int lat, bc;
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      go(1, {7'd0, i[2]}, {7'd0, i[1]}, i[0], lat, bc);
      e = 2'(int'(i[2]) + int'(i[1]) + int'(i[0]));
      checks++; if (lat != 1) begin errors++; $display("FAIL fa_latency[%0d] got %0d want 1", i, lat); end
      checks++; if ({carry[1], sum1} !== e) begin errors++; $display("FAIL fa_result[%0d] got %b%b want %b", i, carry[1], sum1, e); end
    end
  endtask

  task automatic test_random;
    int lat, bc, r, sel, w;
    logic [7:0] x, y;
    logic ci;
    for (int i = 0; i < 24; i++) begin
      sel = (i % 2 == 0) ? 0 : 2;
      w = 8;
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
      r = model(w, x, y, ci, sub);
      go(sel, x, y, ci, lat, bc);
      checks++; if (lat != ((sel == 0) ? 8 : 2)) begin errors++; $display("FAIL rand_latency[%0d] got %0d", i, lat); end
      checks++; if ({carry[sel], sum_of(sel)} !== 9'(r)) begin
        errors++; $display("FAIL rand_result[%0d] sel=%0d got %b_%h want %h", i, sel, carry[sel], sum_of(sel), 9'(r));
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, r;
    logic [7:0] x, y;
    logic ci;
    go(2, 8'h3C, 8'hA5, 1'b1, lat, bc);
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency1 got %0d want 2", lat); end
    checks++; if ({carry[2], sum8c} !== 9'h0E2) begin errors++; $display("FAIL b2b_result1 got %b_%h want 0_e2", carry[2], sum8c); end
    x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
    r = model(8, x, y, ci, sub);
    a = x; b = y; cin = ci; start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy[2]); end
    lat = 0;
    while (!done[2] && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency2 got %0d want 2", lat); end
    checks++; if ({carry[2], sum8c} !== 9'(r)) begin errors++; $display("FAIL b2b_result2 got %b_%h want %h", carry[2], sum8c, 9'(r)); end
  endtask

  task automatic test_ignore;
    int pulses = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done[0]) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++; if ({carry[0], sum8a} !== 9'h030) begin errors++; $display("FAIL ignore_result got %b_%h want 0_30", carry[0], sum8a); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, r, pulses = 0;
    go(0, 8'h5A, 8'h33, 1'b1, lat, bc);
    @(negedge clk);
    a = 8'hC3; b = 8'h7E; cin = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %b%b want 00", busy[0], done[0]); end
    checks++; if ({carry[0], sum8a} !== 9'h000) begin errors++; $display("FAIL rstmid_result got %b_%h want 0_00", carry[0], sum8a); end
    for (int i = 0; i < 12; i++) begin
      if (done[0]) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses got %0d want 0", pulses); end
    r = model(8, 8'h81, 8'h92, 1'b0, sub);
    go(0, 8'h81, 8'h92, 1'b0, lat, bc);
    checks++; if (lat != 8 || {carry[0], sum8a} !== 9'(r)) begin
      errors++; $display("FAIL rstmid_fresh got lat=%0d %b_%h want 8 %h", lat, carry[0], sum8a, 9'(r));
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat, bc;
    sub = 1'b1;
    go(0, 8'h05, 8'h07, 1'b0, lat, bc);
    checks++; if ({carry[0], sum8a} !== 9'h0FE) begin errors++; $display("FAIL sub_borrow got %b_%h want 0_fe", carry[0], sum8a); end
    go(0, 8'h07, 8'h05, 1'b0, lat, bc);
    checks++; if ({carry[0], sum8a} !== 9'h102) begin errors++; $display("FAIL sub_noborrow got %b_%h want 1_02", carry[0], sum8a); end
    test_random();
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_adder();
    test_random();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
